// File: rtl/axi_arbiter_2m.sv
// axi_arbiter_2m: two AXI masters onto one slave port; write and read paths
// arbitrate independently with round-robin priority and purely combinational routing.
module axi_arbiter_2m #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 8,
  parameter int SIZE_BITS = 3
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic                   m0_aw_valid,
  input  logic [ADDR_BITS-1:0]   m0_aw_addr,
  input  logic [LEN_BITS-1:0]    m0_aw_len,
  input  logic [SIZE_BITS-1:0]   m0_aw_size,
  input  logic [1:0]             m0_aw_burst,
  input  logic [3:0]             m0_aw_cache,
  output logic                   m0_aw_ready,
  input  logic                   m0_w_valid,
  input  logic [DATA_BITS-1:0]   m0_w_data,
  input  logic [DATA_BITS/8-1:0] m0_w_strb,
  input  logic                   m0_w_last,
  output logic                   m0_w_ready,
  output logic                   m0_b_valid,
  output logic [1:0]             m0_b_resp,
  input  logic                   m0_b_ready,
  input  logic                   m0_ar_valid,
  input  logic [ADDR_BITS-1:0]   m0_ar_addr,
  input  logic [LEN_BITS-1:0]    m0_ar_len,
  input  logic [SIZE_BITS-1:0]   m0_ar_size,
  input  logic [1:0]             m0_ar_burst,
  input  logic [3:0]             m0_ar_cache,
  output logic                   m0_ar_ready,
  output logic                   m0_r_valid,
  output logic [DATA_BITS-1:0]   m0_r_data,
  output logic [1:0]             m0_r_resp,
  output logic                   m0_r_last,
  input  logic                   m0_r_ready,
  input  logic                   m1_aw_valid,
  input  logic [ADDR_BITS-1:0]   m1_aw_addr,
  input  logic [LEN_BITS-1:0]    m1_aw_len,
  input  logic [SIZE_BITS-1:0]   m1_aw_size,
  input  logic [1:0]             m1_aw_burst,
  input  logic [3:0]             m1_aw_cache,
  output logic                   m1_aw_ready,
  input  logic                   m1_w_valid,
  input  logic [DATA_BITS-1:0]   m1_w_data,
  input  logic [DATA_BITS/8-1:0] m1_w_strb,
  input  logic                   m1_w_last,
  output logic                   m1_w_ready,
  output logic                   m1_b_valid,
  output logic [1:0]             m1_b_resp,
  input  logic                   m1_b_ready,
  input  logic                   m1_ar_valid,
  input  logic [ADDR_BITS-1:0]   m1_ar_addr,
  input  logic [LEN_BITS-1:0]    m1_ar_len,
  input  logic [SIZE_BITS-1:0]   m1_ar_size,
  input  logic [1:0]             m1_ar_burst,
  input  logic [3:0]             m1_ar_cache,
  output logic                   m1_ar_ready,
  output logic                   m1_r_valid,
  output logic [DATA_BITS-1:0]   m1_r_data,
  output logic [1:0]             m1_r_resp,
  output logic                   m1_r_last,
  input  logic                   m1_r_ready,
  output logic                   s_aw_valid,
  output logic [ADDR_BITS-1:0]   s_aw_addr,
  output logic [LEN_BITS-1:0]    s_aw_len,
  output logic [SIZE_BITS-1:0]   s_aw_size,
  output logic [1:0]             s_aw_burst,
  output logic [3:0]             s_aw_cache,
  input  logic                   s_aw_ready,
  output logic                   s_w_valid,
  output logic [DATA_BITS-1:0]   s_w_data,
  output logic [DATA_BITS/8-1:0] s_w_strb,
  output logic                   s_w_last,
  input  logic                   s_w_ready,
  input  logic                   s_b_valid,
  input  logic [1:0]             s_b_resp,
  output logic                   s_b_ready,
  output logic                   s_ar_valid,
  output logic [ADDR_BITS-1:0]   s_ar_addr,
  output logic [LEN_BITS-1:0]    s_ar_len,
  output logic [SIZE_BITS-1:0]   s_ar_size,
  output logic [1:0]             s_ar_burst,
  output logic [3:0]             s_ar_cache,
  input  logic                   s_ar_ready,
  input  logic                   s_r_valid,
  input  logic [DATA_BITS-1:0]   s_r_data,
  input  logic [1:0]             s_r_resp,
  input  logic                   s_r_last,
  output logic                   s_r_ready,
  output logic                   wr_busy,
  output logic                   rd_busy,
  output logic                   wr_gnt,
  output logic                   rd_gnt,
  output logic                   wr_len_err
);
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  wr_state_t wr_state, wr_state_d;
  rd_state_t rd_state, rd_state_d;
  logic wr_gnt_d, wr_prio, wr_prio_d, wr_err_d, rd_gnt_d, rd_prio, rd_prio_d;
  logic [LEN_BITS-1:0] wr_cnt, wr_cnt_d;
  logic wa, wd, wb, ra, rd;
  logic aw0, aw1, w0, w1, b0, b1, ar0, ar1, r0, r1;
  assign wa = wr_state == WR_ADDR;
  assign wd = wr_state == WR_DATA;
  assign wb = wr_state == WR_RESP;
  assign ra = rd_state == RD_ADDR;
  assign rd = rd_state == RD_DATA;
  assign wr_busy = wr_state != WR_IDLE;
  assign rd_busy = rd_state != RD_IDLE;
  assign aw0 = wa & ~wr_gnt;
  assign aw1 = wa & wr_gnt;
  assign w0  = wd & ~wr_gnt;
  assign w1  = wd & wr_gnt;
  assign b0  = wb & ~wr_gnt;
  assign b1  = wb & wr_gnt;
  assign ar0 = ra & ~rd_gnt;
  assign ar1 = ra & rd_gnt;
  assign r0  = rd & ~rd_gnt;
  assign r1  = rd & rd_gnt;
  // slave-bound payload follows the grant; only valids are gated by phase
  assign s_aw_valid = (aw0 & m0_aw_valid) | (aw1 & m1_aw_valid);
  assign s_aw_addr  = wr_gnt ? m1_aw_addr  : m0_aw_addr;
  assign s_aw_len   = wr_gnt ? m1_aw_len   : m0_aw_len;
  assign s_aw_size  = wr_gnt ? m1_aw_size  : m0_aw_size;
  assign s_aw_burst = wr_gnt ? m1_aw_burst : m0_aw_burst;
  assign s_aw_cache = wr_gnt ? m1_aw_cache : m0_aw_cache;
  assign s_w_valid  = (w0 & m0_w_valid) | (w1 & m1_w_valid);
  assign s_w_data   = wr_gnt ? m1_w_data : m0_w_data;
  assign s_w_strb   = wr_gnt ? m1_w_strb : m0_w_strb;
  assign s_w_last   = wr_gnt ? m1_w_last : m0_w_last;
  assign s_b_ready  = (b0 & m0_b_ready) | (b1 & m1_b_ready);
  assign s_ar_valid = (ar0 & m0_ar_valid) | (ar1 & m1_ar_valid);
  assign s_ar_addr  = rd_gnt ? m1_ar_addr  : m0_ar_addr;
  assign s_ar_len   = rd_gnt ? m1_ar_len   : m0_ar_len;
  assign s_ar_size  = rd_gnt ? m1_ar_size  : m0_ar_size;
  assign s_ar_burst = rd_gnt ? m1_ar_burst : m0_ar_burst;
  assign s_ar_cache = rd_gnt ? m1_ar_cache : m0_ar_cache;
  assign s_r_ready  = (r0 & m0_r_ready) | (r1 & m1_r_ready);
  // master-bound signals are forced to zero for whichever master is not the owner
  assign m0_aw_ready = aw0 & s_aw_ready;
  assign m1_aw_ready = aw1 & s_aw_ready;
  assign m0_w_ready  = w0 & s_w_ready;
  assign m1_w_ready  = w1 & s_w_ready;
  assign m0_b_valid  = b0 & s_b_valid;
  assign m1_b_valid  = b1 & s_b_valid;
  assign m0_b_resp   = b0 ? s_b_resp : 2'b00;
  assign m1_b_resp   = b1 ? s_b_resp : 2'b00;
  assign m0_ar_ready = ar0 & s_ar_ready;
  assign m1_ar_ready = ar1 & s_ar_ready;
  assign m0_r_valid  = r0 & s_r_valid;
  assign m1_r_valid  = r1 & s_r_valid;
  assign m0_r_data   = r0 ? s_r_data : '0;
  assign m1_r_data   = r1 ? s_r_data : '0;
  assign m0_r_resp   = r0 ? s_r_resp : 2'b00;
  assign m1_r_resp   = r1 ? s_r_resp : 2'b00;
  assign m0_r_last   = r0 & s_r_last;
  assign m1_r_last   = r1 & s_r_last;
  always_comb begin
    wr_state_d = wr_state;
    wr_gnt_d   = wr_gnt;
    wr_prio_d  = wr_prio;
    wr_cnt_d   = wr_cnt;
    wr_err_d   = wr_len_err;
    case (wr_state)
      WR_IDLE: if (m0_aw_valid || m1_aw_valid) begin
        wr_gnt_d   = (m0_aw_valid && m1_aw_valid) ? wr_prio : m1_aw_valid;
        wr_state_d = WR_ADDR;
      end
      WR_ADDR: if (s_aw_valid && s_aw_ready) begin
        wr_cnt_d   = s_aw_len;
        wr_state_d = WR_DATA;
      end
      WR_DATA: if (s_w_valid && s_w_ready) begin
        wr_cnt_d = wr_cnt - LEN_BITS'(wr_cnt != '0);
        wr_err_d = wr_len_err | (s_w_last ^ (wr_cnt == '0));
        if (s_w_last) wr_state_d = WR_RESP;
      end
      default: if (s_b_valid && s_b_ready) begin
        wr_prio_d  = ~wr_gnt;
        wr_state_d = WR_IDLE;
      end
    endcase
  end
  always_comb begin
    rd_state_d = rd_state;
    rd_gnt_d   = rd_gnt;
    rd_prio_d  = rd_prio;
    case (rd_state)
      RD_IDLE: if (m0_ar_valid || m1_ar_valid) begin
        rd_gnt_d   = (m0_ar_valid && m1_ar_valid) ? rd_prio : m1_ar_valid;
        rd_state_d = RD_ADDR;
      end
      RD_ADDR: if (s_ar_valid && s_ar_ready) rd_state_d = RD_DATA;
      default: if (s_r_valid && s_r_ready && s_r_last) begin
        rd_prio_d  = ~rd_gnt;
        rd_state_d = RD_IDLE;
      end
    endcase
  end
  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) begin
      wr_state   <= WR_IDLE;
      rd_state   <= RD_IDLE;
      wr_gnt     <= 1'b0;
      rd_gnt     <= 1'b0;
      wr_prio    <= 1'b0;
      rd_prio    <= 1'b0;
      wr_cnt     <= '0;
      wr_len_err <= 1'b0;
    end else begin
      wr_state   <= wr_state_d;
      rd_state   <= rd_state_d;
      wr_gnt     <= wr_gnt_d;
      rd_gnt     <= rd_gnt_d;
      wr_prio    <= wr_prio_d;
      rd_prio    <= rd_prio_d;
      wr_cnt     <= wr_cnt_d;
      wr_len_err <= wr_err_d;
    end
endmodule

// File: tb/tb_axi_arbiter_2m.sv
// tb_axi_arbiter_2m: directed bench with a simple slave model and queue scoreboards
// for grant order, W data at the slave and R data at the masters.
module tb_axi_arbiter_2m;
  localparam int AB = 32, DB = 32, LB = 8, SB = 3;
  logic aclk = 1'b0, areset_n = 1'b1;
  always #5 aclk = ~aclk;
  logic aw_valid[2], aw_ready[2], w_valid[2], w_ready[2], w_last[2], b_valid[2], b_ready[2];
  logic ar_valid[2], ar_ready[2], r_valid[2], r_ready[2], r_last[2];
  logic [AB-1:0] aw_addr[2], ar_addr[2];
  logic [LB-1:0] aw_len[2], ar_len[2];
  logic [DB-1:0] w_data[2], r_data[2];
  logic [1:0] b_resp[2], r_resp[2];
  logic s_aw_valid, s_w_valid, s_w_last, s_b_ready, s_ar_valid, s_r_valid, s_r_last, s_r_ready;
  logic [AB-1:0] s_aw_addr, s_ar_addr;
  logic [LB-1:0] s_aw_len, s_ar_len;
  logic [SB-1:0] s_aw_size, s_ar_size;
  logic [1:0] s_aw_burst, s_ar_burst, s_b_resp, s_r_resp;
  logic [3:0] s_aw_cache, s_ar_cache;
  logic [DB-1:0] s_w_data, s_r_data;
  logic [DB/8-1:0] s_w_strb;
  logic wr_busy, rd_busy, wr_gnt, rd_gnt, wr_len_err;
  logic s_w_ready = 1'b0, s_b_valid = 1'b0, r_active = 1'b0, r_go = 1'b0, rnd = 1'b0;
  logic [AB-1:0] r_base = '0;
  logic [LB-1:0] r_len_q = '0, r_idx = '0;
  logic [AB:0] wgq[$], rgq[$];
  logic [DB-1:0] wq[$];
  logic [DB:0] rq[$];
  int vectors = 0, miscompares = 0, cyc = 0, b_t = 0, gap = 0;

  axi_arbiter_2m dut (
    .aclk(aclk), .areset_n(areset_n),
    .m0_aw_valid(aw_valid[0]), .m0_aw_addr(aw_addr[0]), .m0_aw_len(aw_len[0]), .m0_aw_size(3'd2),
    .m0_aw_burst(2'b01), .m0_aw_cache(4'd0), .m0_aw_ready(aw_ready[0]),
    .m0_w_valid(w_valid[0]), .m0_w_data(w_data[0]), .m0_w_strb(4'hf), .m0_w_last(w_last[0]), .m0_w_ready(w_ready[0]),
    .m0_b_valid(b_valid[0]), .m0_b_resp(b_resp[0]), .m0_b_ready(b_ready[0]),
    .m0_ar_valid(ar_valid[0]), .m0_ar_addr(ar_addr[0]), .m0_ar_len(ar_len[0]), .m0_ar_size(3'd2),
    .m0_ar_burst(2'b01), .m0_ar_cache(4'd0), .m0_ar_ready(ar_ready[0]),
    .m0_r_valid(r_valid[0]), .m0_r_data(r_data[0]), .m0_r_resp(r_resp[0]), .m0_r_last(r_last[0]), .m0_r_ready(r_ready[0]),
    .m1_aw_valid(aw_valid[1]), .m1_aw_addr(aw_addr[1]), .m1_aw_len(aw_len[1]), .m1_aw_size(3'd2),
    .m1_aw_burst(2'b01), .m1_aw_cache(4'd0), .m1_aw_ready(aw_ready[1]),
    .m1_w_valid(w_valid[1]), .m1_w_data(w_data[1]), .m1_w_strb(4'hf), .m1_w_last(w_last[1]), .m1_w_ready(w_ready[1]),
    .m1_b_valid(b_valid[1]), .m1_b_resp(b_resp[1]), .m1_b_ready(b_ready[1]),
    .m1_ar_valid(ar_valid[1]), .m1_ar_addr(ar_addr[1]), .m1_ar_len(ar_len[1]), .m1_ar_size(3'd2),
    .m1_ar_burst(2'b01), .m1_ar_cache(4'd0), .m1_ar_ready(ar_ready[1]),
    .m1_r_valid(r_valid[1]), .m1_r_data(r_data[1]), .m1_r_resp(r_resp[1]), .m1_r_last(r_last[1]), .m1_r_ready(r_ready[1]),
    .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
    .s_aw_burst(s_aw_burst), .s_aw_cache(s_aw_cache), .s_aw_ready(1'b1),
    .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last), .s_w_ready(s_w_ready),
    .s_b_valid(s_b_valid), .s_b_resp(s_b_resp), .s_b_ready(s_b_ready),
    .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst), .s_ar_cache(s_ar_cache), .s_ar_ready(1'b1),
    .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last), .s_r_ready(s_r_ready),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .wr_len_err(wr_len_err)
  );

  // slave: always accepts addresses, optionally throttles W ready and R valid
  assign s_b_resp  = 2'b01;
  assign s_r_resp  = 2'b01;
  assign s_r_valid = r_active & r_go;
  assign s_r_data  = r_base + DB'(r_idx);
  assign s_r_last  = r_idx == r_len_q;
  always @(posedge aclk or negedge areset_n)
    if (!areset_n) begin
      s_w_ready <= 1'b0;
      s_b_valid <= 1'b0;
      r_active  <= 1'b0;
      r_go      <= 1'b0;
      r_idx     <= '0;
    end else begin
      s_w_ready <= rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      r_go      <= rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_b_valid && s_b_ready) s_b_valid <= 1'b0;
      else if (s_w_valid && s_w_ready && s_w_last) s_b_valid <= 1'b1;
      if (s_ar_valid) begin
        r_active <= 1'b1;
        r_base   <= s_ar_addr;
        r_len_q  <= s_ar_len;
        r_idx    <= '0;
      end else if (s_r_valid && s_r_ready) begin
        r_idx <= r_idx + 1'b1;
        if (s_r_last) r_active <= 1'b0;
      end
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int k, input int m);
    case (k)
      0: return aw_ready[m];
      1: return w_ready[m];
      2: return b_valid[m];
      3: return ar_ready[m];
      default: return r_valid[m] & r_last[m] & r_ready[m];
    endcase
  endfunction

  // returns at the falling edge before the handshake edge
  task automatic wait_hs(input int k, input int m, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge aclk);
      ok = sig(k, m);
    end
    vectors++;
    assert (ok) else begin
      miscompares++;
      $error("FAIL %s timeout m%0d observed=0 expected=1", tag, m);
    end
  endtask

  task automatic expw(input int m, input logic [AB-1:0] a);
    wgq.push_back({m[0], a});
  endtask

  task automatic expr(input int m, input logic [AB-1:0] a);
    rgq.push_back({m[0], a});
  endtask

  task automatic mwrite(input int m, input int len, input int nb, input logic [AB-1:0] base);
    aw_valid[m] = 1'b1;
    aw_addr[m]  = base;
    aw_len[m]   = LB'(len);
    wait_hs(0, m, "aw_wait");
    @(posedge aclk);
    #1 aw_valid[m] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      w_valid[m] = 1'b1;
      w_data[m]  = base + DB'(i);
      w_last[m]  = i == nb - 1;
      wq.push_back(base + DB'(i));
      wait_hs(1, m, "w_wait");
      @(posedge aclk);
      #1;
    end
    w_valid[m] = 1'b0;
    w_last[m]  = 1'b0;
    b_ready[m] = 1'b1;
    wait_hs(2, m, "b_wait");
    chk("b_route", {b_resp[m], b_valid[1-m], b_resp[1-m]}, 5'b01000);
    @(posedge aclk);
    #1 b_ready[m] = 1'b0;
  endtask

  task automatic mread(input int m, input int len, input logic [AB-1:0] base);
    ar_valid[m] = 1'b1;
    ar_addr[m]  = base;
    ar_len[m]   = LB'(len);
    r_ready[m]  = 1'b1;
    wait_hs(3, m, "ar_wait");
    for (int i = 0; i <= len; i++) rq.push_back({m[0], base + DB'(i)});
    @(posedge aclk);
    #1 ar_valid[m] = 1'b0;
    wait_hs(4, m, "r_wait");
    @(posedge aclk);
    #1 r_ready[m] = 1'b0;
  endtask

  always @(negedge aclk) begin
    cyc++;
    if (s_b_valid && s_b_ready) b_t = cyc;
    if (s_aw_valid) begin
      gap = cyc - b_t;
      chk("aw_route", {wr_gnt, s_aw_addr}, wgq.size() > 0 ? wgq.pop_front() : 'x);
    end
    if (s_w_valid && s_w_ready) begin
      chk("w_route", s_w_data, wq.size() > 0 ? wq.pop_front() : 'x);
      chk("w_other_ready", wr_gnt ? w_ready[0] : w_ready[1], 0);
    end
    if (s_ar_valid) chk("ar_route", {rd_gnt, s_ar_addr}, rgq.size() > 0 ? rgq.pop_front() : 'x);
    for (int m = 0; m < 2; m++)
      if (r_valid[m] && r_ready[m]) begin
        chk("r_beat", {m[0], r_data[m], r_resp[m]}, {(rq.size() > 0 ? rq.pop_front() : 33'bx), 2'b01});
        chk("r_other", {r_valid[1-m], r_data[1-m], r_resp[1-m]}, 0);
      end
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      aw_valid[m] = 1'b1; w_valid[m] = 1'b1; ar_valid[m] = 1'b1;
      b_ready[m] = 1'b1; r_ready[m] = 1'b1; w_last[m] = 1'b0;
      aw_addr[m] = '0; ar_addr[m] = '0; aw_len[m] = '0; ar_len[m] = '0; w_data[m] = '0;
    end
    #1 areset_n = 1'b0;
    #1;
    chk("rst_status", {wr_busy, rd_busy, wr_gnt, rd_gnt, wr_len_err}, 0);
    chk("rst_slave", {s_aw_valid, s_w_valid, s_ar_valid, s_b_ready, s_r_ready}, 0);
    chk("rst_master", {aw_ready[0], aw_ready[1], w_ready[0], w_ready[1], ar_ready[0], ar_ready[1],
                       b_valid[0], b_valid[1], r_valid[0], r_valid[1]}, 0);
    repeat (3) @(posedge aclk);
    for (int m = 0; m < 2; m++) begin
      aw_valid[m] = 1'b0; w_valid[m] = 1'b0; ar_valid[m] = 1'b0; b_ready[m] = 1'b0; r_ready[m] = 1'b0;
    end
    @(negedge aclk) areset_n = 1'b1;
    @(posedge aclk);
    #1;
    // simultaneous write requests: m0 first, m1 right after one arbitration cycle
    expw(0, 32'h1000);
    expw(1, 32'h2000);
    fork
      mwrite(0, 3, 4, 32'h1000);
      mwrite(1, 3, 4, 32'h2000);
    join
    chk("arb_gap", gap, 2);
    chk("len_err_clean", wr_len_err, 0);
    // concurrent write by m1 and read by m0
    expw(1, 32'h3000);
    expr(0, 32'h4000);
    fork
      mwrite(1, 0, 1, 32'h3000);
      mread(0, 7, 32'h4000);
      begin
        repeat (3) @(negedge aclk);
        chk("conc_gnt", {wr_busy, wr_gnt, rd_busy, rd_gnt}, 4'b1110);
      end
    join
    chk("len_err_len0", wr_len_err, 0);
    // early w_last: error set, FSM still reaches response phase
    expw(0, 32'h5000);
    mwrite(0, 3, 2, 32'h5000);
    chk("len_err_set", wr_len_err, 1);
    // throttled slave
    rnd = 1'b1;
    expw(0, 32'h7000);
    expr(1, 32'h6000);
    fork
      mwrite(0, 5, 6, 32'h7000);
      mread(1, 5, 32'h6000);
    join
    rnd = 1'b0;
    chk("len_err_sticky", wr_len_err, 1);
    repeat (2) @(posedge aclk);
    #1;
    // reset in the middle of an m1 write burst
    expw(1, 32'h8000);
    aw_valid[1] = 1'b1;
    aw_addr[1]  = 32'h8000;
    aw_len[1]   = 8'd7;
    wait_hs(0, 1, "aw_wait");
    @(posedge aclk);
    #1 aw_valid[1] = 1'b0;
    w_valid[1] = 1'b1;
    w_data[1]  = 32'h8000;
    wq.push_back(32'h8000);
    wq.push_back(32'h8000);
    @(negedge aclk);
    @(negedge aclk);
    #2 areset_n = 1'b0;
    #1;
    chk("rst_async", {wr_busy, wr_gnt, s_w_valid, w_ready[1], w_ready[0], s_aw_valid}, 0);
    chk("rst_err", wr_len_err, 0);
    chk("rst_drained", wq.size(), 0);
    w_valid[1] = 1'b0;
    @(negedge aclk) areset_n = 1'b1;
    @(posedge aclk);
    #1;
    expw(0, 32'h9000);
    expw(1, 32'hA000);
    fork
      mwrite(0, 0, 1, 32'h9000);
      mwrite(1, 0, 1, 32'hA000);
    join
    // m0 requests back to back, m1 once: m0, m1, m0; reads round-robin too
    expw(0, 32'hB000);
    expw(1, 32'hC000);
    expw(0, 32'hD000);
    expr(0, 32'hE000);
    expr(1, 32'hF000);
    fork
      begin
        mwrite(0, 1, 2, 32'hB000);
        mwrite(0, 1, 2, 32'hD000);
      end
      mwrite(1, 1, 2, 32'hC000);
      mread(0, 2, 32'hE000);
      mread(1, 2, 32'hF000);
    join
    repeat (2) @(posedge aclk);
    #1;
    chk("idle_end", {wr_busy, rd_busy}, 0);
    chk("sb_empty", wgq.size() + wq.size() + rgq.size() + rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi_arbiter_2m.md
AXI_ARBITER_2M -- requirements
Module: axi_arbiter_2m

Interface
REQ-001 Parameter ADDR_BITS, 32, address width on all AW/AR buses.
REQ-002 Parameter DATA_BITS, 32, data width on all W/R buses; strobe width DATA_BITS/8.
REQ-003 Parameter LEN_BITS, 8, burst length width (beats = len+1).
REQ-004 Parameter SIZE_BITS, 3, burst size width.
REQ-005 aclk  in  1  clock; all logic on rising edge.
REQ-006 areset_n  in  1  reset, asynchronous, active-low.
REQ-007 mN_aw_{valid,addr,len,size,burst,cache}  in, mN_aw_ready  out  (N=0,1)  master write-address bundles.
REQ-008 mN_w_{valid,data,strb,last}  in, mN_w_ready  out  master write-data bundles.
REQ-009 mN_b_{valid,resp[1:0]}  out, mN_b_ready  in  master write-response bundles.
REQ-010 mN_ar_{valid,addr,len,size,burst,cache}  in, mN_ar_ready  out  master read-address bundles.
REQ-011 mN_r_{valid,data,resp[1:0],last}  out, mN_r_ready  in  master read-data bundles.
REQ-012 s_aw_*, s_w_*, s_b_*, s_ar_*, s_r_*  mirrored directions  single shared slave-port bundles.
REQ-013 wr_busy, rd_busy  out  1  write/read path owned by a master.
REQ-014 wr_gnt, rd_gnt  out  1  index of current owner (valid only while busy).
REQ-015 wr_len_err  out  1  sticky: W burst beat count disagreed with latched aw_len.

Function
REQ-016 Write and read paths SHALL arbitrate independently and concurrently; one master may own write while the other owns read.
REQ-017 Write FSM states WR_IDLE, WR_ADDR, WR_DATA, WR_RESP; read FSM states RD_IDLE, RD_ADDR, RD_DATA.
REQ-018 WR_IDLE: if any mN_aw_valid, register grant and go WR_ADDR next cycle; no AW forwarded in WR_IDLE (1-cycle arbitration latency).
REQ-019 Both request same cycle: grant SHALL go to wr_prio (resp. rd_prio) pointer; single requester always wins.
REQ-020 WR_ADDR: s_aw_* = granted master's aw_*; granted mN_aw_ready = s_aw_ready; on s_aw handshake latch aw_len into beat counter, go WR_DATA.
REQ-021 WR_DATA: route granted W to slave, s_w_ready back to granted master; each W handshake decrements counter; handshake with w_last goes WR_RESP.
REQ-022 w_last with counter != 0, or counter == 0 without w_last, SHALL set wr_len_err; FSM still advances only on w_last.
REQ-023 WR_RESP: route s_b_valid/s_b_resp to granted master, its b_ready to slave; on b handshake go WR_IDLE, wr_prio <= ~wr_gnt.
REQ-024 RD_ADDR/RD_DATA analogous: AR forwarded, on AR handshake go RD_DATA; R routed to granted master; handshake with r_last goes RD_IDLE, rd_prio <= ~rd_gnt.
REQ-025 Non-granted master SHALL see all ready/valid outputs 0 and data/resp outputs 0; slave sees valid 0 from any idle path.
REQ-026 Grant SHALL be held until burst completion even if granted master drops valid (protocol violation, not recovered).
REQ-027 Routing paths SHALL be combinational (no added beat latency after grant); only grant, state, pointers, counter, error registered.
REQ-028 Back-to-back bursts: same master re-requesting while other waits SHALL lose next arbitration (round-robin fairness).

Reset
REQ-029 areset_n low SHALL immediately force both FSMs to IDLE, wr_prio=rd_prio=0, wr_gnt=rd_gnt=0, busy=0, wr_len_err=0, counter=0.
REQ-030 During and after reset all valid/ready outputs SHALL be 0 until a new grant; a burst in flight at reset is abandoned.

Verification
REQ-031 m0 and m1 assert aw_valid same cycle after reset -> m0 granted, 4-beat burst (len=3) completes, then m1 granted without idle gap beyond 1 arbitration cycle.
REQ-032 m1 write len=0 while m0 read len=7 concurrently -> wr_gnt=1, rd_gnt=0, both complete, no cross-routing of data.
REQ-033 m0 sends w_last on beat 2 of len=3 burst -> wr_len_err=1 and stays 1; FSM enters WR_RESP.
REQ-034 s_w_ready/s_r_valid randomly deasserted -> every beat delivered in order to owner, other master sees ready/valid 0.
REQ-035 areset_n pulsed low mid-burst in WR_DATA -> outputs zero same cycle, wr_busy=0, next request arbitrated from wr_prio=0.
REQ-036 m0 requests continuously, m1 requests once -> grants alternate m0, m1, m0.
